// File: rtl/ysyx_22040750_axi_rd_arbiter_if.sv
// Bus bundle for the N-channel AXI read arbiter: upstream per-channel AR/R slices plus the
// single memory-side AR/R port. The arbiter takes the slave modport, the environment takes master.
interface ysyx_22040750_axi_rd_arbiter_if #(
    parameter int NCH = 2,
    parameter int AW  = 32,
    parameter int DW  = 64
);
    logic [NCH*AW-1:0] I_ch_araddr;
    logic [NCH-1:0]    I_ch_arvalid;
    logic [NCH*8-1:0]  I_ch_arlen;
    logic [NCH*3-1:0]  I_ch_arsize;
    logic [NCH*2-1:0]  I_ch_arburst;
    logic [NCH-1:0]    O_ch_arready;
    logic [NCH*DW-1:0] O_ch_rdata;
    logic [NCH-1:0]    O_ch_rvalid;
    logic [NCH-1:0]    O_ch_rlast;
    logic [NCH-1:0]    I_ch_rready;
    logic [AW-1:0]     O_axi_araddr;
    logic [7:0]        O_axi_arlen;
    logic [2:0]        O_axi_arsize;
    logic [1:0]        O_axi_arburst;
    logic              O_axi_arvalid;
    logic              I_axi_arready;
    logic [DW-1:0]     I_axi_rdata;
    logic              I_axi_rvalid;
    logic              I_axi_rlast;
    logic              O_axi_rready;
    logic [NCH-1:0]    O_grant;
    logic              O_len_err;

    modport slave (
        input  I_ch_araddr, I_ch_arvalid, I_ch_arlen, I_ch_arsize, I_ch_arburst, I_ch_rready,
        input  I_axi_arready, I_axi_rdata, I_axi_rvalid, I_axi_rlast,
        output O_ch_arready, O_ch_rdata, O_ch_rvalid, O_ch_rlast,
        output O_axi_araddr, O_axi_arlen, O_axi_arsize, O_axi_arburst, O_axi_arvalid, O_axi_rready,
        output O_grant, O_len_err
    );

    modport master (
        output I_ch_araddr, I_ch_arvalid, I_ch_arlen, I_ch_arsize, I_ch_arburst, I_ch_rready,
        output I_axi_arready, I_axi_rdata, I_axi_rvalid, I_axi_rlast,
        input  O_ch_arready, O_ch_rdata, O_ch_rvalid, O_ch_rlast,
        input  O_axi_araddr, O_axi_arlen, O_axi_arsize, O_axi_arburst, O_axi_arvalid, O_axi_rready,
        input  O_grant, O_len_err
    );
endinterface

// File: rtl/ysyx_22040750_axi_rd_arbiter.sv
// N-channel AXI4 read arbiter: one burst outstanding, grant held from AR issue to the last R beat,
// fixed-priority or round-robin selection, sticky beat-count error flag.
module ysyx_22040750_axi_rd_arbiter #(
    parameter int NCH = 2,
    parameter int AW  = 32,
    parameter int DW  = 64,
    parameter int RR  = 1
) (
    input logic I_clk,
    input logic I_rst,
    ysyx_22040750_axi_rd_arbiter_if.slave bus
);
    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t          state, state_nxt;
    logic [NCH-1:0]  grant, win_onehot;
    logic [IW-1:0]   gidx, last_grant, win_idx;
    logic            win_any;
    logic [7:0]      win_len, beat_lim;
    logic [8:0]      beat_cnt;
    logic            len_err;
    logic [AW-1:0]   sel_addr;
    logic [7:0]      sel_len;
    logic [2:0]      sel_size;
    logic [1:0]      sel_burst;
    logic            sel_rready;
    logic            r_hs;

    // Lowest requester wins; in round-robin mode a requester above last_grant takes precedence.
    always_comb begin
        win_any    = 1'b0;
        win_idx    = '0;
        win_len    = '0;
        win_onehot = '0;
        for (int j = NCH - 1; j >= 0; j--) begin
            if (bus.I_ch_arvalid[j]) begin
                win_any = 1'b1;
                win_idx = IW'(j);
            end
        end
        if (RR != 0) begin
            for (int j = NCH - 1; j >= 0; j--) begin
                if (bus.I_ch_arvalid[j] && (IW'(j) > last_grant)) win_idx = IW'(j);
            end
        end
        for (int j = 0; j < NCH; j++) begin
            if (win_idx == IW'(j)) begin
                win_len       = bus.I_ch_arlen[j*8 +: 8];
                win_onehot[j] = 1'b1;
            end
        end
    end

    always_comb begin
        sel_addr   = '0;
        sel_len    = '0;
        sel_size   = '0;
        sel_burst  = '0;
        sel_rready = 1'b0;
        for (int j = 0; j < NCH; j++) begin
            if (gidx == IW'(j)) begin
                sel_addr   = bus.I_ch_araddr[j*AW +: AW];
                sel_len    = bus.I_ch_arlen[j*8 +: 8];
                sel_size   = bus.I_ch_arsize[j*3 +: 3];
                sel_burst  = bus.I_ch_arburst[j*2 +: 2];
                sel_rready = bus.I_ch_rready[j];
            end
        end
    end

    assign r_hs           = (state == DATA) && bus.I_axi_rvalid && sel_rready;
    assign bus.O_ch_rdata = {NCH{bus.I_axi_rdata}};
    assign bus.O_grant    = grant;
    assign bus.O_len_err  = len_err;

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt         = state;
        bus.O_axi_arvalid = 1'b0;
        bus.O_axi_araddr  = '0;
        bus.O_axi_arlen   = '0;
        bus.O_axi_arsize  = '0;
        bus.O_axi_arburst = '0;
        bus.O_axi_rready  = 1'b0;
        bus.O_ch_arready  = '0;
        bus.O_ch_rvalid   = '0;
        bus.O_ch_rlast    = '0;
        case (state)
            IDLE: if (win_any) state_nxt = ADDR;
            ADDR: begin
                bus.O_axi_arvalid = 1'b1;
                bus.O_axi_araddr  = sel_addr;
                bus.O_axi_arlen   = sel_len;
                bus.O_axi_arsize  = sel_size;
                bus.O_axi_arburst = sel_burst;
                bus.O_ch_arready  = grant & {NCH{bus.I_axi_arready}};
                if (bus.I_axi_arready) state_nxt = DATA;
            end
            DATA: begin
                bus.O_axi_rready = sel_rready;
                bus.O_ch_rvalid  = grant & {NCH{bus.I_axi_rvalid}};
                bus.O_ch_rlast   = grant & {NCH{bus.I_axi_rlast}};
                if (r_hs && bus.I_axi_rlast) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            grant      <= '0;
            gidx       <= '0;
            last_grant <= IW'(NCH - 1);
            beat_cnt   <= '0;
            len_err    <= 1'b0;
        end else if (state == IDLE) begin
            if (win_any) begin
                grant    <= win_onehot;
                gidx     <= win_idx;
                beat_cnt <= '0;
            end
        end else if (r_hs) begin
            beat_cnt <= beat_cnt + 9'd1;
            // Last beat must land exactly on arlen; any other beat must land before it.
            if (bus.I_axi_rlast ? (beat_cnt != {1'b0, beat_lim}) : (beat_cnt == {1'b0, beat_lim}))
                len_err <= 1'b1;
            if (bus.I_axi_rlast) begin
                grant      <= '0;
                last_grant <= gidx;
            end
        end
    end

    always_ff @(posedge I_clk) begin
        if (state == IDLE && win_any) beat_lim <= win_len;
    end

endmodule

// File: tb/tb_ysyx_22040750_axi_rd_arbiter.sv
// Directed bench for the AXI read arbiter: per-cycle vector table on a 2-channel round-robin
// instance, plus fixed-priority, 4-channel fairness and asynchronous-reset sequences.
module tb_ysyx_22040750_axi_rd_arbiter;
    logic I_clk = 1'b0;
    logic I_rst;
    always #5 I_clk = ~I_clk;

    localparam logic [31:0] A0 = 32'h1000_0000;
    localparam logic [31:0] A1 = 32'h8000_0040;
    localparam logic [63:0] RD = 64'hDEAD_BEEF_0123_4567;

    ysyx_22040750_axi_rd_arbiter_if #(.NCH(2), .AW(32), .DW(64)) bus_a ();
    ysyx_22040750_axi_rd_arbiter_if #(.NCH(2), .AW(32), .DW(64)) bus_b ();
    ysyx_22040750_axi_rd_arbiter_if #(.NCH(4), .AW(32), .DW(64)) bus_c ();

    ysyx_22040750_axi_rd_arbiter #(.NCH(2), .AW(32), .DW(64), .RR(1)) dut_a (
        .I_clk(I_clk), .I_rst(I_rst), .bus(bus_a.slave));
    ysyx_22040750_axi_rd_arbiter #(.NCH(2), .AW(32), .DW(64), .RR(0)) dut_b (
        .I_clk(I_clk), .I_rst(I_rst), .bus(bus_b.slave));
    ysyx_22040750_axi_rd_arbiter #(.NCH(4), .AW(32), .DW(64), .RR(1)) dut_c (
        .I_clk(I_clk), .I_rst(I_rst), .bus(bus_c.slave));

    typedef struct packed {
        logic [1:0] arv;
        logic [7:0] len0;
        logic       arrdy;
        logic       rv;
        logic       rl;
        logic [1:0] rrdy;
    } in_t;

    typedef struct packed {
        logic [1:0]  grant;
        logic        aarv;
        logic [31:0] aaddr;
        logic [7:0]  alen;
        logic [2:0]  asize;
        logic        rrd;
        logic [1:0]  crv;
        logic [1:0]  crl;
        logic [1:0]  carr;
        logic        err;
    } out_t;

    typedef struct packed {
        in_t  in;
        out_t exp;
    } vec_t;

    int n_run = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input in_t x);
        bus_a.I_ch_arvalid  = x.arv;
        bus_a.I_ch_arlen    = {8'd1, x.len0};
        bus_a.I_axi_arready = x.arrdy;
        bus_a.I_axi_rvalid  = x.rv;
        bus_a.I_axi_rlast   = x.rl;
        bus_a.I_ch_rready   = x.rrdy;
    endtask

    function automatic out_t get_out();
        out_t o;
        o.grant = bus_a.O_grant;
        o.aarv  = bus_a.O_axi_arvalid;
        o.aaddr = bus_a.O_axi_araddr;
        o.alen  = bus_a.O_axi_arlen;
        o.asize = bus_a.O_axi_arsize;
        o.rrd   = bus_a.O_axi_rready;
        o.crv   = bus_a.O_ch_rvalid;
        o.crl   = bus_a.O_ch_rlast;
        o.carr  = bus_a.O_ch_arready;
        o.err   = bus_a.O_len_err;
        return o;
    endfunction

    function automatic vec_t mk(input logic [1:0] arv, input logic [7:0] len0, input logic arrdy,
                                input logic rv, input logic rl, input logic [1:0] rrdy,
                                input logic [1:0] g, input logic aarv, input logic [31:0] addr,
                                input logic [7:0] alen, input logic [2:0] asz, input logic rrd,
                                input logic [1:0] crv, input logic [1:0] crl,
                                input logic [1:0] carr, input logic err);
        vec_t v;
        v.in  = '{arv, len0, arrdy, rv, rl, rrdy};
        v.exp = '{g, aarv, addr, alen, asz, rrd, crv, crl, carr, err};
        return v;
    endfunction

    function automatic vec_t mk_idle(input logic [1:0] arv, input logic [7:0] len0,
                                     input logic rv, input logic err);
        return mk(arv, len0, 1'b0, rv, 1'b0, 2'b11, 2'b00, 1'b0, 32'h0, 8'd0, 3'd0, 1'b0,
                  2'b00, 2'b00, 2'b00, err);
    endfunction

    vec_t vt[27];
    logic [1:0] eb[10];
    logic [3:0] fair_exp[5];
    logic [3:0] gval[5];
    int         gcyc[5];
    int         ng;
    logic [3:0] prev;

    initial begin
        // Main instance: ch1 burst, contended bursts with AR backpressure, R backpressure, length error
        vt[0]  = mk(2'b10, 8'd0, 1'b1, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 32'h0, 8'd0, 3'd0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
        vt[1]  = mk(2'b10, 8'd0, 1'b1, 1'b0, 1'b0, 2'b11, 2'b10, 1'b1, A1, 8'd1, 3'd2, 1'b0, 2'b00, 2'b00, 2'b10, 1'b0);
        vt[2]  = mk(2'b00, 8'd0, 1'b0, 1'b1, 1'b0, 2'b11, 2'b10, 1'b0, 32'h0, 8'd0, 3'd0, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0);
        vt[3]  = mk(2'b00, 8'd0, 1'b0, 1'b1, 1'b1, 2'b11, 2'b10, 1'b0, 32'h0, 8'd0, 3'd0, 1'b1, 2'b10, 2'b10, 2'b00, 1'b0);
        vt[4]  = mk_idle(2'b00, 8'd0, 1'b0, 1'b0);
        vt[5]  = mk_idle(2'b11, 8'd0, 1'b0, 1'b0);
        vt[6]  = mk(2'b11, 8'd0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b01, 1'b1, A0, 8'd0, 3'd3, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
        vt[7]  = mk(2'b11, 8'd0, 1'b0, 1'b1, 1'b1, 2'b11, 2'b01, 1'b1, A0, 8'd0, 3'd3, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
        vt[8]  = vt[6];
        vt[9]  = vt[6];
        vt[10] = vt[6];
        vt[11] = mk(2'b11, 8'd0, 1'b1, 1'b0, 1'b0, 2'b11, 2'b01, 1'b1, A0, 8'd0, 3'd3, 1'b0, 2'b00, 2'b00, 2'b01, 1'b0);
        vt[12] = mk(2'b10, 8'd0, 1'b0, 1'b1, 1'b1, 2'b11, 2'b01, 1'b0, 32'h0, 8'd0, 3'd0, 1'b1, 2'b01, 2'b01, 2'b00, 1'b0);
        vt[13] = mk_idle(2'b11, 8'd0, 1'b0, 1'b0);
        vt[14] = mk(2'b11, 8'd0, 1'b1, 1'b0, 1'b0, 2'b11, 2'b10, 1'b1, A1, 8'd1, 3'd2, 1'b0, 2'b00, 2'b00, 2'b10, 1'b0);
        vt[15] = mk(2'b01, 8'd0, 1'b0, 1'b1, 1'b0, 2'b01, 2'b10, 1'b0, 32'h0, 8'd0, 3'd0, 1'b0, 2'b10, 2'b00, 2'b00, 1'b0);
        vt[16] = mk(2'b01, 8'd0, 1'b0, 1'b1, 1'b0, 2'b11, 2'b10, 1'b0, 32'h0, 8'd0, 3'd0, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0);
        vt[17] = mk(2'b01, 8'd0, 1'b0, 1'b1, 1'b1, 2'b11, 2'b10, 1'b0, 32'h0, 8'd0, 3'd0, 1'b1, 2'b10, 2'b10, 2'b00, 1'b0);
        vt[18] = mk_idle(2'b01, 8'd3, 1'b0, 1'b0);
        vt[19] = mk(2'b01, 8'd3, 1'b1, 1'b0, 1'b0, 2'b11, 2'b01, 1'b1, A0, 8'd3, 3'd3, 1'b0, 2'b00, 2'b00, 2'b01, 1'b0);
        vt[20] = mk(2'b00, 8'd3, 1'b0, 1'b1, 1'b0, 2'b11, 2'b01, 1'b0, 32'h0, 8'd0, 3'd0, 1'b1, 2'b01, 2'b00, 2'b00, 1'b0);
        vt[21] = mk(2'b00, 8'd3, 1'b0, 1'b1, 1'b1, 2'b11, 2'b01, 1'b0, 32'h0, 8'd0, 3'd0, 1'b1, 2'b01, 2'b01, 2'b00, 1'b0);
        vt[22] = mk_idle(2'b10, 8'd3, 1'b0, 1'b1);
        vt[23] = mk(2'b10, 8'd3, 1'b1, 1'b0, 1'b0, 2'b11, 2'b10, 1'b1, A1, 8'd1, 3'd2, 1'b0, 2'b00, 2'b00, 2'b10, 1'b1);
        vt[24] = mk(2'b00, 8'd3, 1'b0, 1'b1, 1'b0, 2'b11, 2'b10, 1'b0, 32'h0, 8'd0, 3'd0, 1'b1, 2'b10, 2'b00, 2'b00, 1'b1);
        vt[25] = mk(2'b00, 8'd3, 1'b0, 1'b1, 1'b1, 2'b11, 2'b10, 1'b0, 32'h0, 8'd0, 3'd0, 1'b1, 2'b10, 2'b10, 2'b00, 1'b1);
        vt[26] = mk_idle(2'b00, 8'd3, 1'b0, 1'b1);

        // Fixed priority with both held: ch0 twice, then ch1 once ch0 drops
        eb = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};
        fair_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        bus_a.I_ch_araddr  = {A1, A0};
        bus_a.I_ch_arsize  = {3'd2, 3'd3};
        bus_a.I_ch_arburst = {2'b01, 2'b01};
        bus_a.I_axi_rdata  = RD;
        drive('{2'b11, 8'd0, 1'b1, 1'b1, 1'b1, 2'b11});

        bus_b.I_ch_araddr = '0; bus_b.I_ch_arlen = '0; bus_b.I_ch_arsize = '0;
        bus_b.I_ch_arburst = '0; bus_b.I_ch_arvalid = 2'b00; bus_b.I_ch_rready = 2'b11;
        bus_b.I_axi_arready = 1'b1; bus_b.I_axi_rdata = '0;
        bus_b.I_axi_rvalid = 1'b1; bus_b.I_axi_rlast = 1'b1;

        bus_c.I_ch_araddr = '0; bus_c.I_ch_arlen = '0; bus_c.I_ch_arsize = '0;
        bus_c.I_ch_arburst = '0; bus_c.I_ch_arvalid = 4'hF; bus_c.I_ch_rready = 4'hF;
        bus_c.I_axi_arready = 1'b1; bus_c.I_axi_rdata = '0;
        bus_c.I_axi_rvalid = 1'b1; bus_c.I_axi_rlast = 1'b1;

        I_rst = 1'b1;
        repeat (2) @(negedge I_clk);
        #2;
        check("reset_outputs", 64'(get_out()), 64'(out_t'(0)));
        check("reset_grant_c", 64'(bus_c.O_grant), 64'h0);
        @(negedge I_clk);
        drive('{2'b00, 8'd0, 1'b0, 1'b0, 1'b0, 2'b11});
        I_rst = 1'b0;

        // 4-channel round-robin fairness, all channels requesting continuously
        ng = 0;
        prev = 4'b0000;
        for (int cyc = 0; cyc < 30 && ng < 5; cyc++) begin
            @(negedge I_clk);
            #2;
            if (bus_c.O_grant != 4'b0000 && prev == 4'b0000) begin
                gval[ng] = bus_c.O_grant;
                gcyc[ng] = cyc;
                ng++;
            end
            prev = bus_c.O_grant;
        end
        check("fair_count", 64'(ng), 64'd5);
        for (int k = 0; k < ng; k++) begin
            check($sformatf("fair_grant%0d", k), 64'(gval[k]), 64'(fair_exp[k]));
            if (k > 0) check($sformatf("fair_gap%0d", k), 64'(gcyc[k] - gcyc[k-1] >= 3), 64'd1);
        end

        // Fixed-priority instance
        @(negedge I_clk);
        bus_b.I_ch_arvalid = 2'b11;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge I_clk);
            if (i == 6) bus_b.I_ch_arvalid = 2'b10;
            #2;
            check($sformatf("fixed_grant%0d", i), 64'(bus_b.O_grant), 64'(eb[i]));
        end
        bus_b.I_ch_arvalid = 2'b00;

        // Main vector table
        for (int i = 0; i < 27; i++) begin
            @(negedge I_clk);
            drive(vt[i].in);
            #2;
            check($sformatf("vec%0d", i), 64'(get_out()), 64'(vt[i].exp));
        end

        // ch0 burst completes, then ch1 burst is cut by an asynchronous reset in DATA
        @(negedge I_clk); drive('{2'b01, 8'd0, 1'b1, 1'b0, 1'b0, 2'b11});
        @(negedge I_clk); drive('{2'b00, 8'd0, 1'b1, 1'b0, 1'b0, 2'b11});
        @(negedge I_clk); drive('{2'b00, 8'd0, 1'b0, 1'b1, 1'b1, 2'b11});
        @(negedge I_clk); drive('{2'b10, 8'd0, 1'b0, 1'b0, 1'b0, 2'b11});
        @(negedge I_clk); drive('{2'b10, 8'd0, 1'b1, 1'b0, 1'b0, 2'b11});
        @(negedge I_clk); drive('{2'b00, 8'd0, 1'b0, 1'b1, 1'b0, 2'b11});
        #2;
        check("pre_rst_rvalid", 64'(bus_a.O_ch_rvalid), 64'h2);
        check("rdata_ch0", bus_a.O_ch_rdata[63:0], RD);
        check("rdata_ch1", bus_a.O_ch_rdata[127:64], RD);
        #1 I_rst = 1'b1;
        #1;
        check("rst_async_outputs", 64'(get_out()), 64'(out_t'(0)));
        @(negedge I_clk);
        I_rst = 1'b0;
        drive('{2'b11, 8'd0, 1'b0, 1'b0, 1'b0, 2'b11});
        @(negedge I_clk);
        #2;
        check("post_rst_grant", 64'(bus_a.O_grant), 64'h1);
        check("post_rst_arvalid", 64'(bus_a.O_axi_arvalid), 64'h1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
